// File: rtl/vend_credit_fsm.sv
// Vending credit/dispense controller: holds running credit, drives the external
// 3-bit adder, dispenses on reaching PRICE and pays change/refund as unit pulses.
module vend_credit_fsm #(
  parameter logic [2:0] PRICE = 3'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_coin_valid,
  input  logic [2:0] i_coin,
  input  logic       i_cancel,
  output logic [2:0] o_add_a,
  output logic [2:0] o_add_b,
  output logic       o_add_cin,
  input  logic [2:0] i_add_sum,
  input  logic       i_add_cout,
  output logic       o_ready,
  output logic       o_dispense,
  output logic       o_change_pulse,
  output logic       o_coin_reject
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_REFUND
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [3:0] chg_q, chg_d;
  logic       rej_q, rej_d;

  logic       ready;
  logic       coin_nz;
  logic       accept;
  logic [3:0] total;
  logic [3:0] price4;

  assign price4  = {1'b0, PRICE};
  assign total   = {i_add_cout, i_add_sum};
  assign coin_nz = (i_coin != 3'd0);
  assign ready   = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign accept  = ready & i_coin_valid & ~i_cancel & coin_nz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= 3'd0;
      chg_q    <= 4'd0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    chg_d    = chg_q;
    // A strobe is dropped when busy, or when a cancel in the same cycle wins.
    rej_d    = i_coin_valid & (~ready | (i_cancel & coin_nz));
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          if (total >= price4) begin
            credit_d = 3'd0;
            chg_d    = total - price4;
            state_d  = S_DISPENSE;
          end else begin
            credit_d = total[2:0];
            state_d  = S_COLLECT;
          end
        end else if (i_cancel && (state_q == S_COLLECT)) begin
          chg_d    = {1'b0, credit_q};
          credit_d = 3'd0;
          state_d  = S_REFUND;
        end
      end
      S_DISPENSE: begin
        state_d = (chg_q != 4'd0) ? S_REFUND : S_IDLE;
      end
      S_REFUND: begin
        chg_d = (chg_q != 4'd0) ? (chg_q - 4'd1) : 4'd0;
        if (chg_q <= 4'd1) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_ready        = ready;
    o_dispense     = (state_q == S_DISPENSE);
    o_change_pulse = (state_q == S_REFUND);
    o_coin_reject  = rej_q;
    o_add_a        = credit_q;
    o_add_b        = accept ? i_coin : 3'd0;
    o_add_cin      = 1'b0;
  end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm with a behavioural 3-bit adder in the loop.
// Pulse outputs are tallied per cycle; checks sample at the falling edge.
module tb_vend_credit_fsm;

  logic       clk;
  logic       rst_n;
  logic       cv;
  logic [2:0] coin;
  logic       cancel;
  logic [2:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       ready, disp, pulse, rej;

  int total = 0;
  int bad   = 0;
  int ndisp = 0;
  int npul  = 0;
  int nrej  = 0;

  vend_credit_fsm dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_coin_valid  (cv),
    .i_coin        (coin),
    .i_cancel      (cancel),
    .o_add_a       (add_a),
    .o_add_b       (add_b),
    .o_add_cin     (add_cin),
    .i_add_sum     (add_sum),
    .i_add_cout    (add_cout),
    .o_ready       (ready),
    .o_dispense    (disp),
    .o_change_pulse(pulse),
    .o_coin_reject (rej)
  );

  logic [3:0] adder_out;
  assign adder_out = {1'b0, add_a} + {1'b0, add_b} + {3'd0, add_cin};
  assign add_sum   = adder_out[2:0];
  assign add_cout  = adder_out[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (disp)  ndisp++;
    if (pulse) npul++;
    if (rej)   nrej++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ndisp = 0;
    npul  = 0;
    nrej  = 0;
  endtask

  task automatic coin_in(input logic [2:0] v);
    @(negedge clk);
    cv   = 1'b1;
    coin = v;
    @(negedge clk);
    cv   = 1'b0;
    coin = 3'd0;
  endtask

  initial begin
    rst_n  = 1'b0;
    cv     = 1'b0;
    coin   = 3'd0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_credit", int'(add_a), 0);
    chk("rst_disp", int'(disp), 0);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_rej", int'(rej), 0);
    chk("rst_cin", int'(add_cin), 0);
    rst_n = 1'b1;

    // 1: 2 + 2 exact price
    @(negedge clk);
    clr();
    coin_in(3'd2);
    chk("t1_credit2", int'(add_a), 2);
    chk("t1_ready", int'(ready), 1);
    coin_in(3'd2);
    chk("t1_disp_now", int'(disp), 1);
    chk("t1_busy", int'(ready), 0);
    chk("t1_credit0", int'(add_a), 0);
    repeat (4) @(negedge clk);
    chk("t1_ndisp", ndisp, 1);
    chk("t1_npul", npul, 0);
    chk("t1_idle", int'(ready), 1);

    // 2: 3 + 5 = 8 -> change 4
    clr();
    coin_in(3'd3);
    cv   = 1'b1;
    coin = 3'd5;
    #1;
    chk("t2_addb", int'(add_b), 5);
    chk("t2_sum", int'(add_sum), 0);
    chk("t2_cout", int'(add_cout), 1);
    @(negedge clk);
    cv   = 1'b0;
    coin = 3'd0;
    chk("t2_disp_k1", int'(disp), 1);
    chk("t2_nopulse_k1", int'(pulse), 0);
    @(negedge clk);
    chk("t2_pulse_k2", int'(pulse), 1);
    chk("t2_disp_off", int'(disp), 0);
    repeat (6) @(negedge clk);
    chk("t2_ndisp", ndisp, 1);
    chk("t2_npul", npul, 4);
    chk("t2_idle", int'(ready), 1);

    // 3: coin 3 then cancel -> refund 3
    clr();
    coin_in(3'd3);
    chk("t3_credit3", int'(add_a), 3);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("t3_credit0", int'(add_a), 0);
    chk("t3_pulse", int'(pulse), 1);
    repeat (5) @(negedge clk);
    chk("t3_ndisp", ndisp, 0);
    chk("t3_npul", npul, 3);
    chk("t3_ready", int'(ready), 1);

    // 4: coin 7 -> change 3; coin strobe during refund is rejected
    clr();
    coin_in(3'd7);
    chk("t4_disp", int'(disp), 1);
    @(negedge clk);
    chk("t4_refund", int'(pulse), 1);
    cv   = 1'b1;
    coin = 3'd2;
    #1;
    chk("t4_addb0", int'(add_b), 0);
    @(negedge clk);
    cv   = 1'b0;
    coin = 3'd0;
    chk("t4_rej", int'(rej), 1);
    repeat (5) @(negedge clk);
    chk("t4_npul", npul, 3);
    chk("t4_nrej", nrej, 1);
    chk("t4_credit", int'(add_a), 0);
    chk("t4_ndisp", ndisp, 1);

    // 5: coin with cancel in idle -> coin dropped
    clr();
    cv     = 1'b1;
    coin   = 3'd1;
    cancel = 1'b1;
    @(negedge clk);
    cv     = 1'b0;
    coin   = 3'd0;
    cancel = 1'b0;
    chk("t5_rej", int'(rej), 1);
    chk("t5_credit", int'(add_a), 0);
    chk("t5_ready", int'(ready), 1);
    @(negedge clk);
    chk("t5_rej_off", int'(rej), 0);
    chk("t5_npul", npul, 0);

    // zero-value strobe is a no-op
    cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
    chk("z_norej", int'(rej), 0);
    chk("z_credit", int'(add_a), 0);

    // 6: reset during refund
    clr();
    coin_in(3'd7);
    @(negedge clk);
    chk("t6_pulse", int'(pulse), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_pulse0", int'(pulse), 0);
    chk("t6_disp0", int'(disp), 0);
    chk("t6_credit0", int'(add_a), 0);
    chk("t6_ready", int'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    coin_in(3'd3);
    chk("t6_newcoin", int'(add_a), 3);
    repeat (3) @(negedge clk);
    chk("t6_npul", npul, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
